// File: rtl/nfc_sram_arb_if.sv
// Requester port bundle for the page SRAM arbiter: request/address/write side
// driven by the requester, grant and read return driven by the arbiter.
interface nfc_sram_arb_if #(
  parameter int AW = 13,
  parameter int DW = 16
);
  logic          req;
  logic [AW-1:0] addr;
  logic [1:0]    wen;
  logic [DW-1:0] wdat;
  logic          gnt;
  logic          rvld;
  logic [DW-1:0] rdat;

  modport master (
    output req, addr, wen, wdat,
    input  gnt, rvld, rdat
  );

  modport slave (
    input  req, addr, wen, wdat,
    output gnt, rvld, rdat
  );
endinterface

// File: rtl/nfc_sram_arb.sv
// Page SRAM arbiter: NFC has top priority, ECC/MIF share round-robin, and a
// starvation limiter forces a low-priority grant after STARVE_LIM NFC grants.
module nfc_sram_arb #(
  parameter int AW         = 13,
  parameter int DW         = 16,
  parameter int STARVE_LIM = 8
) (
  input  logic          nfc_clk,
  input  logic          rst_nfc,
  nfc_sram_arb_if.slave nfc,
  nfc_sram_arb_if.slave ecc,
  nfc_sram_arb_if.slave mif,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cen,
  output logic [1:0]    sram_wen,
  output logic [DW-1:0] sram_wr_dat,
  input  logic [DW-1:0] sram_rd_dat,
  output logic          arb_starve
);

  localparam logic [1:0] OWN_NFC = 2'd0;
  localparam logic [1:0] OWN_ECC = 2'd1;
  localparam logic [1:0] OWN_MIF = 2'd2;
  localparam logic [7:0] LIM     = 8'(STARVE_LIM);

  logic          rr_ptr_q, rr_ptr_d;
  logic [7:0]    starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_q;
  logic          cen_q;
  logic [1:0]    wen_q;
  logic [DW-1:0] wdat_q;
  logic          tag1_vld_q, tag2_vld_q;
  logic [1:0]    tag1_own_q, tag2_own_q;

  logic          lo_req, rr_ecc, force_lo, any_gnt;
  logic          gnt_nfc, gnt_ecc, gnt_mif;
  logic [AW-1:0] iss_addr;
  logic [1:0]    iss_wen;
  logic [DW-1:0] iss_wdat;
  logic [1:0]    iss_own;

  always_comb begin
    lo_req   = ecc.req | mif.req;
    // ECC wins the low-priority slot if it is alone or it is its turn
    rr_ecc   = ecc.req & (~mif.req | ~rr_ptr_q);
    force_lo = lo_req && (starve_cnt_q == LIM);
    gnt_nfc  = 1'b0;
    gnt_ecc  = 1'b0;
    gnt_mif  = 1'b0;
    if (!rst_nfc) begin
      if (force_lo) begin
        gnt_ecc = rr_ecc;
        gnt_mif = ~rr_ecc;
      end else if (nfc.req) begin
        gnt_nfc = 1'b1;
      end else if (lo_req) begin
        gnt_ecc = rr_ecc;
        gnt_mif = ~rr_ecc;
      end
    end
    any_gnt    = gnt_nfc | gnt_ecc | gnt_mif;
    arb_starve = force_lo & ~rst_nfc;

    rr_ptr_d = rr_ptr_q;
    if (gnt_ecc) rr_ptr_d = 1'b1;
    if (gnt_mif) rr_ptr_d = 1'b0;

    starve_cnt_d = starve_cnt_q;
    if (gnt_ecc || gnt_mif || !lo_req) begin
      starve_cnt_d = 8'd0;
    end else if (gnt_nfc && starve_cnt_q != LIM) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    iss_addr = nfc.addr;
    iss_wen  = nfc.wen;
    iss_wdat = nfc.wdat;
    iss_own  = OWN_NFC;
    if (gnt_ecc) begin
      iss_addr = ecc.addr;
      iss_wen  = ecc.wen;
      iss_wdat = ecc.wdat;
      iss_own  = OWN_ECC;
    end else if (gnt_mif) begin
      iss_addr = mif.addr;
      iss_wen  = mif.wen;
      iss_wdat = mif.wdat;
      iss_own  = OWN_MIF;
    end
  end

  always_ff @(posedge nfc_clk or posedge rst_nfc) begin
    if (rst_nfc) begin
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= 8'd0;
      addr_q       <= '0;
      cen_q        <= 1'b1;
      wen_q        <= 2'b11;
      wdat_q       <= '0;
      tag1_vld_q   <= 1'b0;
      tag1_own_q   <= OWN_NFC;
      tag2_vld_q   <= 1'b0;
      tag2_own_q   <= OWN_NFC;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      if (any_gnt) begin
        addr_q <= iss_addr;
        cen_q  <= 1'b0;
        wen_q  <= iss_wen;
        wdat_q <= iss_wdat;
      end else begin
        cen_q  <= 1'b1;
        wen_q  <= 2'b11;
      end
      // Tag only reads; writes never return data
      tag1_vld_q <= any_gnt && (iss_wen == 2'b11);
      tag1_own_q <= iss_own;
      tag2_vld_q <= tag1_vld_q;
      tag2_own_q <= tag1_own_q;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_cen    = cen_q;
  assign sram_wen    = wen_q;
  assign sram_wr_dat = wdat_q;

  assign nfc.gnt  = gnt_nfc;
  assign ecc.gnt  = gnt_ecc;
  assign mif.gnt  = gnt_mif;
  assign nfc.rvld = tag2_vld_q && (tag2_own_q == OWN_NFC);
  assign ecc.rvld = tag2_vld_q && (tag2_own_q == OWN_ECC);
  assign mif.rvld = tag2_vld_q && (tag2_own_q == OWN_MIF);
  assign nfc.rdat = sram_rd_dat;
  assign ecc.rdat = sram_rd_dat;
  assign mif.rdat = sram_rd_dat;

endmodule

// File: tb/tb_nfc_sram_arb.sv
// Directed bench for nfc_sram_arb with a behavioural byte-writable SRAM model;
// inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_nfc_sram_arb;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          nfc_clk = 1'b0;
  logic          rst_nfc = 1'b1;
  logic [AW-1:0] sram_addr;
  logic          sram_cen;
  logic [1:0]    sram_wen;
  logic [DW-1:0] sram_wr_dat;
  logic [DW-1:0] sram_rd_dat = '0;
  logic          arb_starve;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int tests = 0;
  int fails = 0;

  nfc_sram_arb_if #(.AW(AW), .DW(DW)) nfc_if ();
  nfc_sram_arb_if #(.AW(AW), .DW(DW)) ecc_if ();
  nfc_sram_arb_if #(.AW(AW), .DW(DW)) mif_if ();

  nfc_sram_arb #(.AW(AW), .DW(DW), .STARVE_LIM(4)) dut (
    .nfc_clk     (nfc_clk),
    .rst_nfc     (rst_nfc),
    .nfc         (nfc_if),
    .ecc         (ecc_if),
    .mif         (mif_if),
    .sram_addr   (sram_addr),
    .sram_cen    (sram_cen),
    .sram_wen    (sram_wen),
    .sram_wr_dat (sram_wr_dat),
    .sram_rd_dat (sram_rd_dat),
    .arb_starve  (arb_starve)
  );

  always #5 nfc_clk = ~nfc_clk;

  always @(posedge nfc_clk) begin
    if (!sram_cen) begin
      if (sram_wen == 2'b11) begin
        sram_rd_dat <= mem[sram_addr];
      end else begin
        if (!sram_wen[0]) mem[sram_addr][7:0]  <= sram_wr_dat[7:0];
        if (!sram_wen[1]) mem[sram_addr][15:8] <= sram_wr_dat[15:8];
      end
    end
  end

  logic [2:0] gnt_v, rvld_v;
  assign gnt_v  = {mif_if.gnt, ecc_if.gnt, nfc_if.gnt};
  assign rvld_v = {mif_if.rvld, ecc_if.rvld, nfc_if.rvld};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge nfc_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge nfc_clk);
  endtask

  // who: 0 = nfc, 1 = ecc, 2 = mif
  task automatic drv(input int who, input logic r, input logic [AW-1:0] a,
                     input logic [1:0] w, input logic [DW-1:0] d);
    case (who)
      0: begin nfc_if.req = r; nfc_if.addr = a; nfc_if.wen = w; nfc_if.wdat = d; end
      1: begin ecc_if.req = r; ecc_if.addr = a; ecc_if.wen = w; ecc_if.wdat = d; end
      default: begin mif_if.req = r; mif_if.addr = a; mif_if.wen = w; mif_if.wdat = d; end
    endcase
  endtask

  task automatic clr();
    for (int k = 0; k < 3; k++) drv(k, 1'b0, '0, 2'b11, '0);
  endtask

  task automatic do_reset();
    clr();
    rst_nfc = 1'b1;
    nxt();
    nxt();
    rst_nfc = 1'b0;
  endtask

  logic [2:0] exp_g;
  logic       exp_s;

  initial begin
    // reset state, with all requests asserted to show grants are blocked
    for (int k = 0; k < 3; k++) drv(k, 1'b1, 13'h1FFF, 2'b00, 16'hFFFF);
    mid();
    chk("rst_gnt", 32'(gnt_v), 32'd0);
    chk("rst_rvld", 32'(rvld_v), 32'd0);
    chk("rst_starve", 32'(arb_starve), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_wen", 32'(sram_wen), 32'h3);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_wdat", 32'(sram_wr_dat), 32'd0);
    do_reset();

    // single write then read through MIF
    drv(2, 1'b1, 13'h0100, 2'b00, 16'hA5A5);
    mid(); chk("rd_wr_gnt", 32'(gnt_v), 32'b100);
    nxt(); drv(2, 1'b1, 13'h0100, 2'b11, 16'h0000);
    mid(); chk("rd_rd_gnt", 32'(gnt_v), 32'b100);
    chk("rd_wr_cen", 32'(sram_cen), 32'd0);
    chk("rd_wr_wen", 32'(sram_wen), 32'h0);
    chk("rd_wr_addr", 32'(sram_addr), 32'h100);
    chk("rd_wr_dat", 32'(sram_wr_dat), 32'hA5A5);
    nxt(); clr();
    mid(); chk("rd_cen", 32'(sram_cen), 32'd0);
    chk("rd_wen", 32'(sram_wen), 32'h3);
    chk("rd_wr_norvld", 32'(rvld_v), 32'd0);
    nxt();
    mid(); chk("rd_rvld", 32'(rvld_v), 32'b100);
    chk("rd_rdat", 32'(mif_if.rdat), 32'hA5A5);
    chk("rd_idle_cen", 32'(sram_cen), 32'd1);
    nxt();
    mid(); chk("rd_rvld_off", 32'(rvld_v), 32'd0);

    // fixed priority with one request each
    do_reset();
    drv(0, 1'b1, 13'h0010, 2'b11, 16'h0);
    drv(1, 1'b1, 13'h0020, 2'b11, 16'h0);
    drv(2, 1'b1, 13'h0030, 2'b11, 16'h0);
    mid(); chk("pri_g0", 32'(gnt_v), 32'b001);
    nxt(); drv(0, 1'b0, '0, 2'b11, '0);
    mid(); chk("pri_g1", 32'(gnt_v), 32'b010);
    chk("pri_a0", 32'(sram_addr), 32'h010);
    nxt(); drv(1, 1'b0, '0, 2'b11, '0);
    mid(); chk("pri_g2", 32'(gnt_v), 32'b100);
    chk("pri_a1", 32'(sram_addr), 32'h020);
    chk("pri_v0", 32'(rvld_v), 32'b001);
    nxt(); drv(2, 1'b0, '0, 2'b11, '0);
    mid(); chk("pri_g3", 32'(gnt_v), 32'b000);
    chk("pri_a2", 32'(sram_addr), 32'h030);
    chk("pri_v1", 32'(rvld_v), 32'b010);
    nxt();
    mid(); chk("pri_v2", 32'(rvld_v), 32'b100);

    // byte write merge: 0xFFFF then low byte 0x34
    do_reset();
    drv(0, 1'b1, 13'h0200, 2'b00, 16'hFFFF);
    mid(); chk("bw_g0", 32'(gnt_v), 32'b001);
    nxt(); drv(0, 1'b1, 13'h0200, 2'b10, 16'h1234);
    mid(); chk("bw_g1", 32'(gnt_v), 32'b001);
    chk("bw_wen0", 32'(sram_wen), 32'h0);
    nxt(); drv(0, 1'b1, 13'h0200, 2'b11, 16'h0000);
    mid(); chk("bw_wen1", 32'(sram_wen), 32'h2);
    chk("bw_dat1", 32'(sram_wr_dat), 32'h1234);
    nxt(); clr();
    mid(); chk("bw_rd_wen", 32'(sram_wen), 32'h3);
    chk("bw_rd_cen", 32'(sram_cen), 32'd0);
    nxt();
    mid(); chk("bw_rvld", 32'(rvld_v), 32'b001);
    chk("bw_rdat", 32'(nfc_if.rdat), 32'hFF34);

    // round-robin between ECC and MIF
    do_reset();
    drv(1, 1'b1, 13'h0040, 2'b11, '0);
    drv(2, 1'b1, 13'h0050, 2'b11, '0);
    mid(); chk("rr_0", 32'(gnt_v), 32'b010); nxt();
    mid(); chk("rr_1", 32'(gnt_v), 32'b100); nxt();
    mid(); chk("rr_2", 32'(gnt_v), 32'b010); nxt();
    mid(); chk("rr_3", 32'(gnt_v), 32'b100); nxt();
    drv(2, 1'b0, '0, 2'b11, '0);
    mid(); chk("rr_solo", 32'(gnt_v), 32'b010); nxt();
    drv(2, 1'b1, 13'h0050, 2'b11, '0);
    mid(); chk("rr_5", 32'(gnt_v), 32'b100); nxt();
    mid(); chk("rr_6", 32'(gnt_v), 32'b010); nxt();

    // starvation limiter at STARVE_LIM = 4; MIF joins from cycle 10
    do_reset();
    drv(0, 1'b1, 13'h0060, 2'b00, 16'h0001);
    drv(1, 1'b1, 13'h0070, 2'b00, 16'h0002);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) drv(2, 1'b1, 13'h0080, 2'b00, 16'h0003);
      exp_g = 3'b001;
      exp_s = 1'b0;
      if (i == 4 || i == 9 || i == 19) begin exp_g = 3'b010; exp_s = 1'b1; end
      if (i == 14) begin exp_g = 3'b100; exp_s = 1'b1; end
      mid();
      chk($sformatf("stv_g%0d", i), 32'(gnt_v), 32'(exp_g));
      chk($sformatf("stv_s%0d", i), 32'(arb_starve), 32'(exp_s));
      nxt();
    end

    // reset asserted the cycle after a read grant
    do_reset();
    drv(1, 1'b1, 13'h0020, 2'b11, '0);
    mid(); chk("mr_gnt", 32'(gnt_v), 32'b010);
    nxt(); clr();
    rst_nfc = 1'b1;
    #1;
    chk("mr_cen", 32'(sram_cen), 32'd1);
    chk("mr_gnt_rst", 32'(gnt_v), 32'd0);
    nxt();
    rst_nfc = 1'b0;
    chk("mr_cnt", 32'(dut.starve_cnt_q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      mid(); chk($sformatf("mr_rvld%0d", i), 32'(rvld_v), 32'd0);
      nxt();
    end
    // pointer must be back at ECC even though ECC was granted last
    drv(1, 1'b1, 13'h0020, 2'b11, '0);
    drv(2, 1'b1, 13'h0030, 2'b11, '0);
    mid(); chk("mr_rr", 32'(gnt_v), 32'b010);
    nxt(); clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nfc_sram_arb.md
# nfc_sram_arb

Arbiter and sequencer for the single-port page SRAM (4.5K x 16) behind the NAND flash controller. Shares the SRAM between three requesters: the NFC datapath (NAND transfer engine), the ECC engine and the MIF host path. The NFC has fixed top priority; ECC and MIF alternate round-robin; a starvation limiter bounds how long NFC can lock out the others. It registers the SRAM control signals and routes read data back to the owner of each access.

## Interface
Parameters:
- AW, 13, SRAM word-address width
- DW, 16, SRAM data width
- STARVE_LIM, 8, consecutive NFC grants tolerated while a low-priority request waits (range 1..255)

Ports (x in {nfc, ecc, mif}; each requester has an identical port set):
- nfc_clk  in  1  sole clock, rising edge
- rst_nfc  in  1  asynchronous, active-high reset
- x_req  in  1  access request; held with addr/wen/wdat stable until x_gnt
- x_addr  in  AW  word address
- x_wen  in  2  active-low byte write enables; 2'b11 = read
- x_wdat  in  DW  write data
- x_gnt  out  1  grant; access accepted in this cycle
- x_rvld  out  1  read data valid for this requester
- x_rdat  out  DW  read data (valid when x_rvld)
- sram_addr  out  AW  registered SRAM address
- sram_cen  out  1  registered chip enable, active-low
- sram_wen  out  2  registered byte write enables, active-low
- sram_wr_dat  out  DW  registered write data
- sram_rd_dat  in  DW  SRAM read data, valid one cycle after the sram_cen-low cycle
- arb_starve  out  1  one-cycle pulse when a starvation-forced grant occurs

## Operation
- Grant decision is combinational from the x_req inputs and internal state; at most one x_gnt is high per cycle.
- Priority:
  - If starve_cnt == STARVE_LIM and ecc_req|mif_req, grant goes to the round-robin winner even if nfc_req is high, and arb_starve pulses.
  - Otherwise nfc_req wins.
  - Otherwise the round-robin winner among ecc/mif wins.
- Round-robin: 1-bit rr_ptr (0 = ECC preferred, 1 = MIF preferred). If only one of ecc/mif requests, it wins regardless of rr_ptr. After any ECC grant rr_ptr <= 1; after any MIF grant rr_ptr <= 0. NFC grants leave rr_ptr unchanged.
- Starvation counter starve_cnt (8 bits, saturating at STARVE_LIM):
  - Increments on an NFC grant while ecc_req|mif_req.
  - Clears on any ECC/MIF grant, and in any cycle with no ecc_req and no mif_req.
- Issue: on a grant, the granted requester's addr/wen/wdat are registered into sram_*, with sram_cen <= 0. With no grant: sram_cen <= 1, sram_wen <= 2'b11, addr/wr_dat hold.
- Read return: a 2-stage owner tag pipeline records {owner, is_read}. For a read granted in cycle N, x_rvld is high in cycle N+2 and x_rdat = sram_rd_dat (combinational pass-through). The other requesters' x_rvld are low in that cycle.
- x_rdat of non-owners: drive sram_rd_dat (shared bus); only x_rvld qualifies it.
- Writes produce no x_rvld.
- Back-to-back grants are allowed every cycle, to any mix of requesters and read/write. There are no stalls and no bubbles.

## Timing
- Reset (async, while rst_nfc = 1):
  - All x_gnt = 0, all x_rvld = 0, arb_starve = 0.
  - sram_cen = 1, sram_wen = 2'b11, sram_addr = 0, sram_wr_dat = 0.
  - rr_ptr = 0, starve_cnt = 0, tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped; no x_rvld after reset release for accesses granted before reset.
- Latency: request accepted in its gnt cycle N. SRAM access occurs in N+1 (sram_cen low). Read data returns in N+2.
- Minimum req-to-gnt latency is 0 cycles (same cycle, when uncontended).
- A requester may keep x_req high after gnt to issue its next access. The next access's addr/wen/wdat must be presented in the cycle after gnt.
- Simultaneous requests from all three requesters: NFC wins until starve_cnt reaches STARVE_LIM. The next grant then goes to ECC or MIF per rr_ptr, starve_cnt clears, and NFC resumes.
- STARVE_LIM bound: any low-priority requester waits at most 2*(STARVE_LIM+1) cycles for a grant.

## Test plan
- Single read: reset, write mif addr 0x0100 data 0xA5A5 (wen 2'b00), then mif read 0x0100 -> mif_gnt in same cycle as req; sram_cen low the next cycle; mif_rvld two cycles after gnt with mif_rdat = 0xA5A5. nfc_rvld and ecc_rvld stay 0.
- Fixed priority: nfc_req, ecc_req and mif_req asserted together for one request each, STARVE_LIM = 8 -> grant order NFC, ECC, MIF in three consecutive cycles; sram_addr sequence matches.
- Starvation: nfc_req held continuously, ecc_req asserted, STARVE_LIM = 4 -> 4 NFC grants, then ecc_gnt with arb_starve pulse, then NFC grants resume. Repeat with mif_req also high -> forced grants alternate ECC, MIF.
- Round-robin: ecc_req and mif_req held high with no NFC -> gnt alternates ECC, MIF, ECC, MIF starting with ECC after reset; a single-requester cycle does not toggle the order unfairly.
- Byte writes: NFC writes wen 2'b10 data 0x1234, then reads back -> sram_wen = 2'b10 on the issue cycle; a read of an address pre-filled with 0xFFFF returns 0xFF34.
- Reset mid-read: assert rst_nfc in the cycle after a read grant -> sram_cen = 1 immediately; no x_rvld after release; rr_ptr = 0 and starve_cnt = 0.
